// File: rtl/adc_spi_sequencer_if.sv
// Signal bundle shared by the trigger logic, the ADC frame sequencer and ADC_READER.
// The sequencer side is the master; the trigger/reader side is the slave.
interface adc_spi_sequencer_if;
  logic        start;
  logic        cont;
  logic [31:0] adc_word;
  logic        AD_CONV;
  logic        SPI_SCK;
  logic        read;
  logic        busy;
  logic [13:0] ch0;
  logic [13:0] ch1;
  logic        sample_valid;

  modport master (
    input  start, cont, adc_word,
    output AD_CONV, SPI_SCK, read, busy, ch0, ch1, sample_valid
  );

  modport slave (
    output start, cont, adc_word,
    input  AD_CONV, SPI_SCK, read, busy, ch0, ch1, sample_valid
  );
endinterface

// File: rtl/adc_spi_sequencer.sv
// Frame sequencer for an LTC1407A-style dual ADC: AD_CONV pulse, SPI_SCK, per-bit read
// strobe, then splits the 32-bit word from ADC_READER into two signed 14-bit samples.
module adc_spi_sequencer #(
  parameter int unsigned HALF_DIV    = 2,
  parameter int unsigned CONV_CYCLES = 2,
  parameter int unsigned FRAME_BITS  = 34
) (
  input  logic                       clk,
  input  logic                       rst,
  adc_spi_sequencer_if.master        bus
);

  localparam int unsigned BIT_PERIOD = 2 * HALF_DIV;
  localparam int          DIV_W      = $clog2(BIT_PERIOD);
  localparam int          BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int          CONV_W     = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BIT_PERIOD - 1);
  localparam logic [DIV_W-1:0]  SCK_RISE  = DIV_W'(HALF_DIV);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);

  if (HALF_DIV < 1 || HALF_DIV > 255) begin : g_bad_half_div
    $error("adc_spi_sequencer: HALF_DIV must be in 1..255");
  end
  if (CONV_CYCLES < 1) begin : g_bad_conv_cycles
    $error("adc_spi_sequencer: CONV_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SHIFT,
    S_LATCH
  } state_e;

  state_e              state_q,    state_d;
  logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q,  div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;

  logic                ad_conv_q,  ad_conv_d;
  logic                sck_q,      sck_d;
  logic                read_q,     read_d;
  logic                busy_q,     busy_d;
  logic                valid_q,    valid_d;
  logic [13:0]         ch0_q,      ch0_d;
  logic [13:0]         ch1_q,      ch1_d;

  // The two don't-care bit pairs of the frame are shifted in but never used.
  logic unused_dont_care;
  assign unused_dont_care = ^{bus.adc_word[17:16], bus.adc_word[1:0]};

  always_comb begin
    // NOTE: every _d signal gets its hold/default value first, so no branch of the case
    // below can leave one unassigned and infer a latch.
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    ch0_d      = ch0_q;
    ch1_d      = ch1_q;
    valid_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start || bus.cont) begin
          state_d    = S_CONV;
          conv_cnt_d = '0;
        end
      end

      S_CONV: begin
        if (conv_cnt_q == CONV_LAST) begin
          state_d   = S_SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          conv_cnt_d = conv_cnt_q + CONV_W'(1);
        end
      end

      S_SHIFT: begin
        // The last count of a bit period is the SCK falling edge where ADC_READER shifts.
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_LATCH;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      S_LATCH: begin
        ch0_d   = bus.adc_word[31:18];
        ch1_d   = bus.adc_word[15:2];
        valid_d = 1'b1;
        if (bus.cont) begin
          state_d    = S_CONV;
          conv_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so that, once registered, they line up
    // with the cycle that state is actually occupied.
    ad_conv_d = (state_d == S_CONV);
    sck_d     = (state_d == S_SHIFT) && (div_cnt_d >= SCK_RISE);
    read_d    = (state_d == S_SHIFT) && (div_cnt_d == DIV_LAST);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      conv_cnt_q <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // the values from before the edge, independent of statement order.
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_conv_q <= 1'b0;
      sck_q     <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      // NOTE: the sample registers are reset too, so a frame aborted by reset never
      // leaves a stale sample visible downstream.
      ch0_q     <= '0;
      ch1_q     <= '0;
    end else begin
      ad_conv_q <= ad_conv_d;
      sck_q     <= sck_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
    end
  end

  assign bus.AD_CONV      = ad_conv_q;
  assign bus.SPI_SCK      = sck_q;
  assign bus.read         = read_q;
  assign bus.busy         = busy_q;
  assign bus.sample_valid = valid_q;
  assign bus.ch0          = ch0_q;
  assign bus.ch1          = ch1_q;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Self-checking bench: two sequencers (HALF_DIV=2 and HALF_DIV=1), each fed by a
// behavioural ADC + ADC_READER model, checked against frame-level timing and data rules.
module tb_adc_spi_sequencer;

  localparam int CONV = 2;
  localparam int FB   = 34;
  localparam int H0   = 2;
  localparam int H1   = 1;
  localparam int LAT0 = CONV + 2 * H0 * FB + 1;  // 139
  localparam int LAT1 = CONV + 2 * H1 * FB + 1;  // 71

  typedef struct {
    int          cyc;
    logic [13:0] c0;
    logic [13:0] c1;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adc_spi_sequencer_if bus0 ();
  adc_spi_sequencer_if bus1 ();

  adc_spi_sequencer #(.HALF_DIV(H0), .CONV_CYCLES(CONV), .FRAME_BITS(FB)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master)
  );
  adc_spi_sequencer #(.HALF_DIV(H1), .CONV_CYCLES(CONV), .FRAME_BITS(FB)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master)
  );

  // ADC + ADC_READER model: a frame is loaded at each AD_CONV rise and shifted MSB first.
  logic [33:0] fq0[$], fq1[$];
  logic [33:0] cur0 = '0, cur1 = '0;
  int          idx0 = 0, idx1 = 0;
  logic [31:0] word0 = '0, word1 = '0;
  logic        crd0 = 1'b0, crd1 = 1'b0;

  assign bus0.adc_word = word0;
  assign bus1.adc_word = word1;

  always @(posedge clk) begin
    if (bus0.AD_CONV === 1'b1 && !crd0) begin
      if (fq0.size() > 0) cur0 = fq0.pop_front();
      else                cur0 = '0;
      idx0 = 0;
    end
    if (bus0.read === 1'b1) begin
      word0 <= {word0[30:0], (idx0 < FB) ? cur0[FB-1-idx0] : 1'b0};
      idx0++;
    end
    crd0 = (bus0.AD_CONV === 1'b1);
  end

  always @(posedge clk) begin
    if (bus1.AD_CONV === 1'b1 && !crd1) begin
      if (fq1.size() > 0) cur1 = fq1.pop_front();
      else                cur1 = '0;
      idx1 = 0;
    end
    if (bus1.read === 1'b1) begin
      word1 <= {word1[30:0], (idx1 < FB) ? cur1[FB-1-idx1] : 1'b0};
      idx1++;
    end
    crd1 = (bus1.AD_CONV === 1'b1);
  end

  // Output monitors, sampled on the falling clock edge.
  int   reads0 = 0, rises0 = 0, convhi0 = 0, badrd0 = 0;
  int   reads1 = 0, rises1 = 0, convhi1 = 0, badrd1 = 0;
  logic sp0 = 1'b0, cp0 = 1'b0, sp1 = 1'b0, cp1 = 1'b0;
  ev_t  ev0[$], ev1[$];
  int   crise0[$], crise1[$];

  always @(negedge clk) begin
    if (bus0.read === 1'b1) begin
      reads0++;
      if (bus0.SPI_SCK !== 1'b1 || bus0.busy !== 1'b1 || bus0.AD_CONV !== 1'b0) badrd0++;
    end
    if (bus0.SPI_SCK === 1'b1 && !sp0) rises0++;
    if (bus0.AD_CONV === 1'b1) begin
      convhi0++;
      if (!cp0) crise0.push_back(cyc);
    end
    sp0 = (bus0.SPI_SCK === 1'b1);
    cp0 = (bus0.AD_CONV === 1'b1);
    if (bus0.sample_valid === 1'b1) ev0.push_back('{cyc, bus0.ch0, bus0.ch1});
  end

  always @(negedge clk) begin
    if (bus1.read === 1'b1) begin
      reads1++;
      if (bus1.SPI_SCK !== 1'b1 || bus1.busy !== 1'b1 || bus1.AD_CONV !== 1'b0) badrd1++;
    end
    if (bus1.SPI_SCK === 1'b1 && !sp1) rises1++;
    if (bus1.AD_CONV === 1'b1) begin
      convhi1++;
      if (!cp1) crise1.push_back(cyc);
    end
    sp1 = (bus1.SPI_SCK === 1'b1);
    cp1 = (bus1.AD_CONV === 1'b1);
    if (bus1.sample_valid === 1'b1) ev1.push_back('{cyc, bus1.ch0, bus1.ch1});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    reads0 = 0; rises0 = 0; convhi0 = 0; badrd0 = 0; ev0.delete(); crise0.delete();
    reads1 = 0; rises1 = 0; convhi1 = 0; badrd1 = 0; ev1.delete(); crise1.delete();
  endtask

  // Frame on the wire: 2 don't-care, ch0, 2 don't-care, ch1, 2 don't-care.
  function automatic logic [33:0] make_frame(input logic [13:0] c0, input logic [13:0] c1);
    logic [1:0] a, b, d;
    a = 2'($urandom_range(3));
    b = 2'($urandom_range(3));
    d = 2'($urandom_range(3));
    return {a, c0, b, c1, d};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 40; i++) begin
      bus0.start = 1'($urandom_range(1)); bus0.cont = 1'($urandom_range(1));
      bus1.start = 1'($urandom_range(1)); bus1.cont = 1'($urandom_range(1));
      step();
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus0.AD_CONV, bus0.SPI_SCK, bus0.read, bus0.busy, bus0.sample_valid,
           bus0.ch0, bus0.ch1} !== 33'd0) begin
        n_bad++;
        $display("FAIL reset_hold_dut0[%0d]: outputs %h, expected 0", i,
                 {bus0.AD_CONV, bus0.SPI_SCK, bus0.read, bus0.busy, bus0.sample_valid,
                  bus0.ch0, bus0.ch1});
      end
      n_cmp++;
      if ({bus1.AD_CONV, bus1.SPI_SCK, bus1.read, bus1.busy, bus1.sample_valid,
           bus1.ch0, bus1.ch1} !== 33'd0) begin
        n_bad++;
        $display("FAIL reset_hold_dut1[%0d]: outputs %h, expected 0", i,
                 {bus1.AD_CONV, bus1.SPI_SCK, bus1.read, bus1.busy, bus1.sample_valid,
                  bus1.ch0, bus1.ch1});
      end
      bus0.start = 1'($urandom_range(1)); bus0.cont = 1'($urandom_range(1));
      bus1.start = 1'($urandom_range(1)); bus1.cont = 1'($urandom_range(1));
      step();
    end
    bus0.start = 1'b0; bus0.cont = 1'b0; bus1.start = 1'b0; bus1.cont = 1'b0;
    rst = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0 || bus0.AD_CONV !== 1'b0 ||
        bus1.AD_CONV !== 1'b0 || bus0.SPI_SCK !== 1'b0 || bus1.SPI_SCK !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_idle: busy %b/%b conv %b/%b sck %b/%b, expected all 0",
               bus0.busy, bus1.busy, bus0.AD_CONV, bus1.AD_CONV, bus0.SPI_SCK, bus1.SPI_SCK);
    end
  endtask

  // One start-triggered frame on the HALF_DIV=2 instance.
  task automatic test_frame0(input logic [13:0] c0, input logic [13:0] c1, input string name);
    int t0, k;
    clear_mon();
    fq0.push_back(make_frame(c0, c1));
    bus0.start = 1'b1;
    t0 = cyc + 1;
    step();
    bus0.start = 1'b0;
    k = 0;
    while (bus0.busy === 1'b1 && k < 400) begin step(); k++; end
    repeat (3) step();
    n_cmp++;
    if (bus0.busy !== 1'b0) begin
      n_bad++; $display("FAIL %s/timeout: busy still %b after budget, expected 0", name, bus0.busy);
    end
    n_cmp++;
    if (ev0.size() != 1) begin
      n_bad++; $display("FAIL %s/valid_count: got %0d pulses, expected 1", name, ev0.size());
    end else begin
      n_cmp++;
      if (ev0[0].cyc - t0 != LAT0) begin
        n_bad++; $display("FAIL %s/latency: got %0d, expected %0d", name, ev0[0].cyc - t0, LAT0);
      end
      n_cmp++;
      if (ev0[0].c0 !== c0 || ev0[0].c1 !== c1) begin
        n_bad++; $display("FAIL %s/data: got ch0=%h ch1=%h, expected ch0=%h ch1=%h",
                          name, ev0[0].c0, ev0[0].c1, c0, c1);
      end
    end
    n_cmp++;
    if (reads0 != FB || rises0 != FB || convhi0 != CONV || badrd0 != 0) begin
      n_bad++; $display("FAIL %s/pulses: reads=%0d rises=%0d conv=%0d badread=%0d, expected %0d %0d %0d 0",
                        name, reads0, rises0, convhi0, badrd0, FB, FB, CONV);
    end
    n_cmp++;
    if (crise0.size() != 1 || (crise0.size() == 1 && crise0[0] != t0)) begin
      n_bad++; $display("FAIL %s/conv_start: %0d rises, first at offset %0d, expected 1 at 0",
                        name, crise0.size(), (crise0.size() > 0) ? crise0[0] - t0 : -1);
    end
    n_cmp++;
    if (bus0.ch0 !== c0 || bus0.ch1 !== c1) begin
      n_bad++; $display("FAIL %s/hold: ch0=%h ch1=%h, expected %h %h", name, bus0.ch0, bus0.ch1, c0, c1);
    end
  endtask

  // Same scenario on the HALF_DIV=1 instance.
  task automatic test_frame1(input logic [13:0] c0, input logic [13:0] c1, input string name);
    int t0, k;
    clear_mon();
    fq1.push_back(make_frame(c0, c1));
    bus1.start = 1'b1;
    t0 = cyc + 1;
    step();
    bus1.start = 1'b0;
    k = 0;
    while (bus1.busy === 1'b1 && k < 200) begin step(); k++; end
    repeat (3) step();
    n_cmp++;
    if (ev1.size() != 1) begin
      n_bad++; $display("FAIL %s/valid_count: got %0d pulses, expected 1", name, ev1.size());
    end else begin
      n_cmp++;
      if (ev1[0].cyc - t0 != LAT1) begin
        n_bad++; $display("FAIL %s/latency: got %0d, expected %0d", name, ev1[0].cyc - t0, LAT1);
      end
      n_cmp++;
      if (ev1[0].c0 !== c0 || ev1[0].c1 !== c1) begin
        n_bad++; $display("FAIL %s/data: got ch0=%h ch1=%h, expected ch0=%h ch1=%h",
                          name, ev1[0].c0, ev1[0].c1, c0, c1);
      end
    end
    n_cmp++;
    if (reads1 != FB || rises1 != FB || convhi1 != CONV || badrd1 != 0) begin
      n_bad++; $display("FAIL %s/pulses: reads=%0d rises=%0d conv=%0d badread=%0d, expected %0d %0d %0d 0",
                        name, reads1, rises1, convhi1, badrd1, FB, FB, CONV);
    end
  endtask

  task automatic test_continuous();
    logic [13:0] a0[3], a1[3];
    int t0, k;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      a0[i] = 14'($urandom);
      a1[i] = 14'($urandom);
      fq0.push_back(make_frame(a0[i], a1[i]));
    end
    bus0.cont = 1'b1;
    t0 = cyc + 1;
    step();
    k = 0;
    while (ev0.size() < 2 && k < 600) begin step(); k++; end
    repeat (20) step();
    bus0.cont = 1'b0;
    k = 0;
    while (bus0.busy === 1'b1 && k < 400) begin step(); k++; end
    repeat (10) step();
    n_cmp++;
    if (ev0.size() != 3) begin
      n_bad++; $display("FAIL cont/valid_count: got %0d pulses, expected 3", ev0.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (ev0[i].cyc - t0 != (i + 1) * LAT0 || ev0[i].c0 !== a0[i] || ev0[i].c1 !== a1[i]) begin
          n_bad++; $display("FAIL cont/frame%0d: offset %0d ch0=%h ch1=%h, expected offset %0d ch0=%h ch1=%h",
                            i, ev0[i].cyc - t0, ev0[i].c0, ev0[i].c1, (i + 1) * LAT0, a0[i], a1[i]);
        end
      end
    end
    n_cmp++;
    if (crise0.size() != 3) begin
      n_bad++; $display("FAIL cont/conv_count: got %0d AD_CONV pulses, expected 3", crise0.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (crise0[i] - t0 != i * LAT0) begin
          n_bad++; $display("FAIL cont/conv_start%0d: offset %0d, expected %0d", i, crise0[i] - t0, i * LAT0);
        end
      end
    end
    n_cmp++;
    if (reads0 != 3 * FB || rises0 != 3 * FB || convhi0 != 3 * CONV || badrd0 != 0 ||
        bus0.busy !== 1'b0) begin
      n_bad++; $display("FAIL cont/pulses: reads=%0d rises=%0d conv=%0d badread=%0d busy=%b, expected %0d %0d %0d 0 0",
                        reads0, rises0, convhi0, badrd0, bus0.busy, 3 * FB, 3 * FB, 3 * CONV);
    end
  endtask

  task automatic test_start_while_busy();
    logic [13:0] c0, c1;
    int t0, k;
    clear_mon();
    c0 = 14'($urandom);
    c1 = 14'($urandom);
    fq0.push_back(make_frame(c0, c1));
    bus0.start = 1'b1;
    t0 = cyc + 1;
    step();
    bus0.start = 1'b0;
    k = 0;
    while (reads0 < 10 && k < 200) begin step(); k++; end
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    k = 0;
    while (bus0.busy === 1'b1 && k < 400) begin step(); k++; end
    repeat (10) step();
    n_cmp++;
    if (ev0.size() != 1 || crise0.size() != 1 || reads0 != FB) begin
      n_bad++; $display("FAIL busy_start/frames: valid=%0d conv=%0d reads=%0d, expected 1 1 %0d",
                        ev0.size(), crise0.size(), reads0, FB);
    end else begin
      n_cmp++;
      if (ev0[0].cyc - t0 != LAT0 || ev0[0].c0 !== c0 || ev0[0].c1 !== c1) begin
        n_bad++; $display("FAIL busy_start/result: offset %0d ch0=%h ch1=%h, expected %0d %h %h",
                          ev0[0].cyc - t0, ev0[0].c0, ev0[0].c1, LAT0, c0, c1);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int k;
    clear_mon();
    fq0.push_back(make_frame(14'h0F0F, 14'h3333));
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    k = 0;
    while (reads0 < 20 && k < 200) begin step(); k++; end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus0.AD_CONV, bus0.SPI_SCK, bus0.read, bus0.busy, bus0.sample_valid} !== 5'd0 ||
        bus0.ch0 !== 14'd0 || bus0.ch1 !== 14'd0) begin
      n_bad++; $display("FAIL reset_mid/outputs: conv=%b sck=%b read=%b busy=%b valid=%b ch0=%h ch1=%h, expected all 0",
                        bus0.AD_CONV, bus0.SPI_SCK, bus0.read, bus0.busy, bus0.sample_valid, bus0.ch0, bus0.ch1);
    end
    step();
    step();
    rst = 1'b0;
    fq0.delete();
    step();
    test_frame0(14'h2A5C, 14'h15A3, "reset_mid/restart");
  endtask

  initial begin
    bus0.start = 1'b0; bus0.cont = 1'b0;
    bus1.start = 1'b0; bus1.cont = 1'b0;
    #2 rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    test_reset();
    test_frame0(14'h1ABC, 14'h2345, "single");
    test_frame0(14'h3FFF, 14'h2000, "extreme");
    test_frame1(14'h3FFF, 14'h2000, "half_div1");
    test_continuous();
    test_start_while_busy();
    test_reset_mid_shift();
    for (int i = 0; i < 3; i++) test_frame0(14'($urandom), 14'($urandom), "random");
    test_frame1(14'($urandom), 14'($urandom), "half_div1_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
